// File: rtl/m3_uart_cmd_rx.sv
// m3_uart_cmd_rx: UART 8N1 receiver decoding ASCII bytes into motor602 command pulses (8E1 with M3_UART_RX_PARITY_EN)
module m3_uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic       rxI,
  output logic [7:0] rxDataO,
  output logic       rxValidO,
  output logic       frameErrO,
  output logic       busyO,
  output logic       m3startO,
  output logic       m3forceStopO,
  output logic       m3invRotateO,
  output logic       m3freqINCo,
  output logic       m3freqDECo,
  output logic       m3powerINCo,
  output logic       m3powerDECo
`ifdef M3_UART_RX_PARITY_EN
  ,
  output logic       parErrO
`endif
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] syncQ;
  logic rxS, rxPrev, armed;
  logic [15:0] cnt;
  logic [2:0] bitIdx;
  logic [7:0] shiftQ;
`ifdef M3_UART_RX_PARITY_EN
  logic parBit;
`endif
  assign rxS = syncQ[SYNC_STAGES-1];
  // Metastability synchronizer and previous-sample register for edge detection; idle line is high
  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      syncQ  <= '1;
      rxPrev <= 1'b1;
    end else begin
      syncQ  <= {syncQ[SYNC_STAGES-2:0], rxI};
      rxPrev <= rxS;
    end
  end
  // Receive FSM: mid-bit sampling, byte assembly and registered command decode
  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      state        <= IDLE;
      cnt          <= '0;
      bitIdx       <= '0;
      shiftQ       <= '0;
      armed        <= 1'b0;
      rxDataO      <= '0;
      rxValidO     <= 1'b0;
      frameErrO    <= 1'b0;
      busyO        <= 1'b0;
      m3startO     <= 1'b0;
      m3forceStopO <= 1'b0;
      m3invRotateO <= 1'b0;
      m3freqINCo   <= 1'b0;
      m3freqDECo   <= 1'b0;
      m3powerINCo  <= 1'b0;
      m3powerDECo  <= 1'b0;
`ifdef M3_UART_RX_PARITY_EN
      parBit       <= 1'b0;
      parErrO      <= 1'b0;
`endif
    end else begin
      rxValidO     <= 1'b0;
      frameErrO    <= 1'b0;
      m3startO     <= 1'b0;
      m3forceStopO <= 1'b0;
      m3freqINCo   <= 1'b0;
      m3freqDECo   <= 1'b0;
      m3powerINCo  <= 1'b0;
      m3powerDECo  <= 1'b0;
`ifdef M3_UART_RX_PARITY_EN
      parErrO      <= 1'b0;
`endif
      if (cnt != '0) cnt <= cnt - 16'd1;
      case (state)
        IDLE: begin
          armed <= armed | rxS;
          busyO <= 1'b0;
          if (armed && rxPrev && !rxS) begin
            state <= START;
            cnt   <= HALF;
            busyO <= 1'b1;
          end
        end
        START: if (cnt == '0) begin
          if (rxS) begin
            state <= IDLE;
            busyO <= 1'b0;
          end else begin
            state  <= DATA;
            cnt    <= FULL;
            bitIdx <= '0;
          end
        end
        DATA: if (cnt == '0) begin
          shiftQ <= {rxS, shiftQ[7:1]};
          bitIdx <= bitIdx + 3'd1;
          cnt    <= FULL;
`ifdef M3_UART_RX_PARITY_EN
          if (bitIdx == 3'd7) state <= PARITY;
`else
          if (bitIdx == 3'd7) state <= STOP;
`endif
        end
`ifdef M3_UART_RX_PARITY_EN
        PARITY: if (cnt == '0) begin
          parBit <= rxS;
          cnt    <= FULL;
          state  <= STOP;
        end
`endif
        STOP: if (cnt == '0) begin
          state <= IDLE;
          if (!rxS) begin
            frameErrO <= 1'b1;
            armed     <= 1'b0;
          end
`ifdef M3_UART_RX_PARITY_EN
          else if (^{shiftQ, parBit}) parErrO <= 1'b1;
`endif
          else begin
            rxValidO     <= 1'b1;
            rxDataO      <= shiftQ;
            m3startO     <= shiftQ == 8'h53;
            m3forceStopO <= shiftQ == 8'h58 || shiftQ == 8'h78;
            m3invRotateO <= m3invRotateO ^ (shiftQ == 8'h52);
            m3freqINCo   <= shiftQ == 8'h2B;
            m3freqDECo   <= shiftQ == 8'h2D;
            m3powerINCo  <= shiftQ == 8'h50;
            m3powerDECo  <= shiftQ == 8'h70;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m3_uart_cmd_rx.sv
// tb_m3_uart_cmd_rx: table-driven bench for m3_uart_cmd_rx at CLKS_PER_BIT=16
module tb_m3_uart_cmd_rx;
  localparam int CPB = 16;
`ifdef M3_UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif
  logic clkI = 1'b0, rstI = 1'b1, rxI = 1'b1, parFlip = 1'b0;
  logic [7:0] rxDataO;
  logic rxValidO, frameErrO, busyO, m3startO, m3forceStopO, m3invRotateO;
  logic m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo;
  logic [5:0] cmdV;
`ifdef M3_UART_RX_PARITY_EN
  logic parErrO;
`endif
  m3_uart_cmd_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clkI(clkI), .rstI(rstI), .rxI(rxI), .rxDataO(rxDataO), .rxValidO(rxValidO),
    .frameErrO(frameErrO), .busyO(busyO), .m3startO(m3startO), .m3forceStopO(m3forceStopO),
    .m3invRotateO(m3invRotateO), .m3freqINCo(m3freqINCo), .m3freqDECo(m3freqDECo),
    .m3powerINCo(m3powerINCo), .m3powerDECo(m3powerDECo)
`ifdef M3_UART_RX_PARITY_EN
    , .parErrO(parErrO)
`endif
  );
  always #5 clkI = ~clkI;
  assign cmdV = {m3powerDECo, m3powerINCo, m3freqDECo, m3freqINCo, m3forceStopO, m3startO};
  int cyc = 0, validCnt = 0, ferrCnt = 0, orphanCnt = 0, parCnt = 0, lastValidCyc = 0, lastBusyCyc = 0;
  int cmdCnt[6] = '{0, 0, 0, 0, 0, 0};
  always @(posedge clkI) cyc <= cyc + 1;
  // Pulse monitor sampled on the falling edge; a command without rxValidO or two at once is an orphan
  always @(negedge clkI) begin
    if (rxValidO) begin validCnt++; lastValidCyc = cyc; end
    if (frameErrO) ferrCnt++;
    if (busyO) lastBusyCyc = cyc;
    for (int i = 0; i < 6; i++) if (cmdV[i]) cmdCnt[i]++;
    if (cmdV != 6'd0 && (!rxValidO || $countones(cmdV) != 1)) orphanCnt++;
`ifdef M3_UART_RX_PARITY_EN
    if (parErrO) parCnt++;
`endif
  end
  int checks = 0, failures = 0;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clkI);
    #1;
  endtask
  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    rxI = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxI = d[i];
      waitCycles(CPB);
    end
`ifdef M3_UART_RX_PARITY_EN
    rxI = ^d ^ parFlip;
    waitCycles(CPB);
`endif
    rxI = stopBit;
    waitCycles(CPB);
    rxI = 1'b1;
  endtask
  typedef struct {
    logic [7:0] d;
    logic       stopBit;
    int         gap;
    logic       expValid;
    logic       expFerr;
    logic [5:0] expCmd;
    logic       expRot;
    logic [7:0] expData;
  } vec_t;
  vec_t vecs[14];
  int v0, f0, o0, p0, c0[6], t0, lat;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{8'h53, 1'b1, 0,  1'b1, 1'b0, 6'b000001, 1'b0, 8'h53};
    vecs[1]  = '{8'h52, 1'b1, 0,  1'b1, 1'b0, 6'b000000, 1'b1, 8'h52};
    vecs[2]  = '{8'h52, 1'b1, 0,  1'b1, 1'b0, 6'b000000, 1'b0, 8'h52};
    vecs[3]  = '{8'h52, 1'b1, 20, 1'b1, 1'b0, 6'b000000, 1'b1, 8'h52};
    vecs[4]  = '{8'h2B, 1'b0, 20, 1'b0, 1'b1, 6'b000000, 1'b1, 8'h52};
    vecs[5]  = '{8'h2D, 1'b1, 0,  1'b1, 1'b0, 6'b001000, 1'b1, 8'h2D};
    vecs[6]  = '{8'h58, 1'b1, 0,  1'b1, 1'b0, 6'b000010, 1'b1, 8'h58};
    vecs[7]  = '{8'h78, 1'b1, 0,  1'b1, 1'b0, 6'b000010, 1'b1, 8'h78};
    vecs[8]  = '{8'h2B, 1'b1, 0,  1'b1, 1'b0, 6'b000100, 1'b1, 8'h2B};
    vecs[9]  = '{8'h50, 1'b1, 0,  1'b1, 1'b0, 6'b010000, 1'b1, 8'h50};
    vecs[10] = '{8'h70, 1'b1, 0,  1'b1, 1'b0, 6'b100000, 1'b1, 8'h70};
    vecs[11] = '{8'h41, 1'b1, 0,  1'b1, 1'b0, 6'b000000, 1'b1, 8'h41};
    vecs[12] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 6'b000000, 1'b1, 8'h00};
    vecs[13] = '{8'hFF, 1'b1, 20, 1'b1, 1'b0, 6'b000000, 1'b1, 8'hFF};
    waitCycles(3);
    check("reset outputs", int'({rxDataO, rxValidO, frameErrO, busyO, m3invRotateO, cmdV}), 0);
    rstI = 1'b0;
    waitCycles(5);
    check("idle busy", int'(busyO), 0);
    for (int i = 0; i < 14; i++) begin
      v0 = validCnt; f0 = ferrCnt; o0 = orphanCnt; c0 = cmdCnt; t0 = cyc;
      sendFrame(vecs[i].d, vecs[i].stopBit);
      waitCycles(vecs[i].gap);
      if (i == 0) begin
        lat = lastValidCyc - t0;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          failures++;
          $display("FAIL latency got=%0d expected=%0d..%0d", lat, LAT - 1, LAT + 1);
        end
      end
      check($sformatf("v%0d valid", i), validCnt - v0, int'(vecs[i].expValid));
      check($sformatf("v%0d frameErr", i), ferrCnt - f0, int'(vecs[i].expFerr));
      for (int k = 0; k < 6; k++) check($sformatf("v%0d cmd%0d", i, k), cmdCnt[k] - c0[k], int'(vecs[i].expCmd[k]));
      check($sformatf("v%0d orphan", i), orphanCnt - o0, 0);
      check($sformatf("v%0d rotate", i), int'(m3invRotateO), int'(vecs[i].expRot));
      check($sformatf("v%0d rxData", i), int'(rxDataO), int'(vecs[i].expData));
    end
    // 5-cycle glitch must be rejected at the start-bit midpoint
    v0 = validCnt; f0 = ferrCnt; o0 = orphanCnt; c0 = cmdCnt; t0 = cyc;
    rxI = 1'b0;
    waitCycles(5);
    rxI = 1'b1;
    waitCycles(40);
    check("glitch valid", validCnt - v0, 0);
    check("glitch frameErr", ferrCnt - f0, 0);
    check("glitch cmds", (cmdCnt[0] - c0[0]) + (cmdCnt[1] - c0[1]) + (cmdCnt[2] - c0[2]) + (cmdCnt[3] - c0[3]) + (cmdCnt[4] - c0[4]) + (cmdCnt[5] - c0[5]), 0);
    check("glitch busy seen", int'(lastBusyCyc > t0), 1);
    check("glitch busy end", int'(lastBusyCyc <= t0 + 10), 1);
    check("glitch busy now", int'(busyO), 0);
    // Reset asserted mid-way through bit 4 of 'P', held until the stop bit
    v0 = validCnt; f0 = ferrCnt; c0 = cmdCnt;
    rxI = 1'b0;
    waitCycles(CPB * 5);
    rxI = 1'b1;
    waitCycles(CPB / 2);
    rstI = 1'b1;
    #1;
    check("midreset busy", int'(busyO), 0);
    waitCycles(CPB / 2);
    rxI = 1'b0; waitCycles(CPB);
    rxI = 1'b1; waitCycles(CPB);
    rxI = 1'b0; waitCycles(CPB);
`ifdef M3_UART_RX_PARITY_EN
    rxI = 1'b0; waitCycles(CPB);
`endif
    rxI = 1'b1;
    waitCycles(4);
    rstI = 1'b0;
    waitCycles(60);
    check("midreset valid", validCnt - v0, 0);
    check("midreset frameErr", ferrCnt - f0, 0);
    check("midreset powerInc", cmdCnt[4] - c0[4], 0);
    check("midreset rxData", int'(rxDataO), 0);
    check("midreset rotate", int'(m3invRotateO), 0);
    v0 = validCnt; c0 = cmdCnt;
    sendFrame(8'h70, 1'b1);
    waitCycles(20);
    check("post reset valid", validCnt - v0, 1);
    check("post reset powerDec", cmdCnt[5] - c0[5], 1);
    check("post reset rxData", int'(rxDataO), 8'h70);
`ifdef M3_UART_RX_PARITY_EN
    v0 = validCnt; c0 = cmdCnt; p0 = parCnt;
    sendFrame(8'h58, 1'b1);
    waitCycles(20);
    check("parity ok forceStop", cmdCnt[1] - c0[1], 1);
    check("parity ok parErr", parCnt - p0, 0);
    v0 = validCnt; c0 = cmdCnt; p0 = parCnt;
    parFlip = 1'b1;
    sendFrame(8'h58, 1'b1);
    waitCycles(20);
    check("parity bad parErr", parCnt - p0, 1);
    check("parity bad forceStop", cmdCnt[1] - c0[1], 0);
    check("parity bad valid", validCnt - v0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
